// File: rtl/sobel_frame_loader.sv
// sobel_frame_loader
//   Input-side frame writer for the Sobel datapath. A raster pixel stream
//   (valid/ready) is written into BRAM0 at sequential addresses. After the
//   last pixel of a frame, the block pulses o_complete with the pixel count.
//   BRAM0 then stays read-only (HOLD) until the consumer asserts i_release.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_start               arm one frame load (sampled in IDLE only)
//   i_release             consumer done with BRAM0 (sampled in HOLD only)
//   s_valid/s_ready       pixel beat handshake; s_ready is high only in LOAD
//   s_data, s_eol         pixel value and end-of-line marker
//   b0_ce0/b0_we0         registered BRAM0 port-0 enable / write enable
//   b0_addr0, b0_d0       registered BRAM0 write address / data
//   o_complete            one-cycle pulse, the cycle after the final write
//   o_num_cnt             pixel count of the last completed frame
//   o_busy                state != IDLE
//   o_err                 sticky line-framing error for current/last frame
module sobel_frame_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IMAGE_W    = 279,
  parameter int IMAGE_H    = 210
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_release,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_eol,
  output logic                  b0_ce0,
  output logic                  b0_we0,
  output logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic [DATA_WIDTH-1:0] b0_d0,
  output logic                  o_complete,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int NPIX = IMAGE_W * IMAGE_H;
  localparam int CW   = (IMAGE_W > 1) ? $clog2(IMAGE_W) : 1;
  localparam int RW   = $clog2(IMAGE_H + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] NPIX_A    = ADDR_WIDTH'(NPIX);
  localparam logic [CW-1:0]         COL_LAST  = CW'(IMAGE_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  // Final beat accepted last cycle; delays o_complete until the final
  // write has actually been captured by BRAM0.
  logic                  r_fin;

  logic w_acc;
  logic w_last;
  logic w_eol_pos;

  assign s_ready   = (r_state == S_LOAD);
  assign o_busy    = (r_state != S_IDLE);
  assign w_acc     = s_valid && s_ready;
  assign w_last    = w_acc && (r_wr_cnt == LAST_ADDR);
  assign w_eol_pos = (r_col == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_cnt   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_fin      <= 1'b0;
      b0_ce0     <= 1'b0;
      b0_we0     <= 1'b0;
      b0_addr0   <= '0;
      b0_d0      <= '0;
      o_complete <= 1'b0;
      o_num_cnt  <= '0;
      o_err      <= 1'b0;
    end else begin
      b0_ce0     <= w_acc;
      b0_we0     <= w_acc;
      r_fin      <= w_last;
      o_complete <= r_fin;
      // Address/data only move on an accept so they hold when idle.
      if (w_acc) begin
        b0_addr0 <= r_wr_cnt;
        b0_d0    <= s_data;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_LOAD;
            r_wr_cnt <= '0;
            r_col    <= '0;
            r_row    <= '0;
            o_err    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_acc) begin
            // Counters are authoritative; s_eol is only cross-checked.
            if (s_eol != w_eol_pos) o_err <= 1'b1;
            if (w_last) begin
              r_state   <= S_HOLD;
              o_num_cnt <= NPIX_A;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
              if (w_eol_pos) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (i_release) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_loader.sv
module tb_sobel_frame_loader;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_release = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_eol = 1'b0;
  logic          b0_ce0, b0_we0;
  logic [AW-1:0] b0_addr0;
  logic [DW-1:0] b0_d0;
  logic          o_complete;
  logic [AW-1:0] o_num_cnt;
  logic          o_busy, o_err;

  int total = 0;
  int bad   = 0;

  sobel_frame_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMAGE_W(W), .IMAGE_H(H)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_release(i_release),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_eol(s_eol),
    .b0_ce0(b0_ce0), .b0_we0(b0_we0), .b0_addr0(b0_addr0), .b0_d0(b0_d0),
    .o_complete(o_complete), .o_num_cnt(o_num_cnt), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // BRAM0 model plus write/complete bookkeeping, captured on the rising edge.
  logic          clr = 1'b0;
  logic [DW-1:0] mem [16];
  int            wr_total, cmp_cnt, cyc, last_we_cyc, comp_cyc;
  bit            order_bad, ce_bad;
  logic [AW-1:0] nxt, num_at_comp;
  logic          err_at_comp;

  initial cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr) begin
      wr_total <= 0; cmp_cnt <= 0; order_bad <= 1'b0; ce_bad <= 1'b0;
      nxt <= '0; last_we_cyc <= -10; comp_cyc <= -20;
      num_at_comp <= '0; err_at_comp <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (b0_we0) begin
        mem[b0_addr0[3:0]] <= b0_d0;
        wr_total <= wr_total + 1;
        if (b0_addr0 != nxt) order_bad <= 1'b1;
        if (b0_ce0 !== 1'b1) ce_bad <= 1'b1;
        nxt <= b0_addr0 + 1'b1;
        last_we_cyc <= cyc;
      end
      if (o_complete) begin
        cmp_cnt <= cmp_cnt + 1;
        comp_cyc <= cyc;
        num_at_comp <= o_num_cnt;
        err_at_comp <= o_err;
      end
    end
  end

  task automatic clear_stats();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    total++;
    if (s_ready !== 1'b1 || o_busy !== 1'b1 || o_err !== 1'b0) begin
      bad++; $display("FAIL start: ready/busy/err=%b%b%b exp 110", s_ready, o_busy, o_err);
    end
  endtask

  // Called at a negedge; each beat is accepted on the following posedge.
  task automatic drive_frame(input int base, input bit gappy, input bit errs);
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b1;
      s_data  = DW'(base + k);
      s_eol   = errs ? (k == 2 || k == 11) : (k % W == W - 1);
      @(negedge clk);
      if (errs) begin
        total++;
        if (o_err !== (k >= 2)) begin
          bad++; $display("FAIL err_beat%0d: o_err=%b exp %b", k, o_err, (k >= 2));
        end
      end
      if (gappy) begin
        s_valid = 1'b0; s_eol = 1'b0;
        @(negedge clk);
        total++;
        if (b0_we0 !== 1'b0 || b0_addr0 !== AW'(k)) begin
          bad++; $display("FAIL gap%0d: we=%b addr=%0d exp we=0 addr=%0d", k, b0_we0, b0_addr0, k);
        end
      end
    end
    s_valid = 1'b0; s_eol = 1'b0;
    total++;
    if (s_ready !== 1'b0 || o_busy !== 1'b1) begin
      bad++; $display("FAIL hold_entry: ready=%b busy=%b exp 0 1", s_ready, o_busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0, o_complete, o_num_cnt, o_busy, o_err} !== '0) begin
      bad++; $display("FAIL reset: ready=%b ce=%b we=%b addr=%0d d=%0h cmp=%b num=%0d busy=%b err=%b",
        s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0, o_complete, o_num_cnt, o_busy, o_err);
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    start_frame();
    drive_frame(8'h10, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++;
      if (mem[i] !== DW'(8'h10 + i)) begin
        bad++; $display("FAIL b2b_mem%0d: got %0h exp %0h", i, mem[i], 8'h10 + i);
      end
    end
    total++;
    if (wr_total != N || order_bad || ce_bad) begin
      bad++; $display("FAIL b2b_writes: n=%0d order_bad=%b ce_bad=%b exp 12 0 0", wr_total, order_bad, ce_bad);
    end
    total++;
    if (cmp_cnt != 1 || comp_cyc != last_we_cyc + 1) begin
      bad++; $display("FAIL b2b_complete: pulses=%0d at=%0d lastwe=%0d exp 1 at lastwe+1", cmp_cnt, comp_cyc, last_we_cyc);
    end
    total++;
    if (num_at_comp !== AW'(N) || err_at_comp !== 1'b0) begin
      bad++; $display("FAIL b2b_num: num=%0d err=%b exp 12 0", num_at_comp, err_at_comp);
    end
    @(negedge clk); i_release = 1'b1;
    @(negedge clk); i_release = 1'b0;
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL release: busy=%b exp 0", o_busy);
    end
  endtask

  task automatic test_gappy();
    clear_stats();
    start_frame();
    drive_frame(8'h10, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++;
      if (mem[i] !== DW'(8'h10 + i)) begin
        bad++; $display("FAIL gappy_mem%0d: got %0h exp %0h", i, mem[i], 8'h10 + i);
      end
    end
    total++;
    if (wr_total != N || order_bad || cmp_cnt != 1 || num_at_comp !== AW'(N)) begin
      bad++; $display("FAIL gappy_sum: n=%0d order_bad=%b pulses=%0d num=%0d exp 12 0 1 12",
        wr_total, order_bad, cmp_cnt, num_at_comp);
    end
    @(negedge clk); i_release = 1'b1;
    @(negedge clk); i_release = 1'b0;
  endtask

  task automatic test_framing_err();
    clear_stats();
    start_frame();
    drive_frame(8'h20, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      total++;
      if (mem[i] !== DW'(8'h20 + i)) begin
        bad++; $display("FAIL ferr_mem%0d: got %0h exp %0h", i, mem[i], 8'h20 + i);
      end
    end
    total++;
    if (wr_total != N || cmp_cnt != 1 || err_at_comp !== 1'b1 || o_err !== 1'b1) begin
      bad++; $display("FAIL ferr_sum: n=%0d pulses=%0d err_at_cmp=%b err=%b exp 12 1 1 1",
        wr_total, cmp_cnt, err_at_comp, o_err);
    end
  endtask

  // Enters still in HOLD from the framing-error frame.
  task automatic test_hold_release();
    clear_stats();
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1; i_start = 1'b1; s_data = 8'hEE;
      @(negedge clk);
      total++;
      if (s_ready !== 1'b0 || b0_we0 !== 1'b0) begin
        bad++; $display("FAIL hold_c%0d: ready=%b we=%b exp 0 0", c, s_ready, b0_we0);
      end
    end
    s_valid = 1'b0; i_start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (wr_total != 0 || cmp_cnt != 0 || o_busy !== 1'b1 || o_err !== 1'b1) begin
      bad++; $display("FAIL hold_sum: n=%0d pulses=%0d busy=%b err=%b exp 0 0 1 1",
        wr_total, cmp_cnt, o_busy, o_err);
    end
    i_release = 1'b1;
    @(negedge clk); i_release = 1'b0;
    start_frame();
    drive_frame(8'h40, 1'b0, 1'b0);
    total++;
    if (mem[0] !== 8'h40 || mem[11] !== 8'h4B || wr_total != N || order_bad || o_err !== 1'b0) begin
      bad++; $display("FAIL reload: m0=%0h m11=%0h n=%0d order_bad=%b err=%b exp 40 4b 12 0 0",
        mem[0], mem[11], wr_total, order_bad, o_err);
    end
    @(negedge clk); i_release = 1'b1;
    @(negedge clk); i_release = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    clear_stats();
    start_frame();
    for (int k = 0; k < 6; k++) begin
      s_valid = 1'b1; s_data = DW'(8'h50 + k); s_eol = (k % W == W - 1);
      @(negedge clk);
    end
    s_data = 8'h56; s_eol = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if ({s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0, o_complete, o_num_cnt, o_busy, o_err} !== '0) begin
      bad++; $display("FAIL midrst: ready=%b ce=%b we=%b addr=%0d d=%0h cmp=%b num=%0d busy=%b err=%b",
        s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0, o_complete, o_num_cnt, o_busy, o_err);
    end
    rst = 1'b0; s_valid = 1'b0;
    clear_stats();
    start_frame();
    drive_frame(8'h60, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      total++;
      if (mem[i] !== DW'(8'h60 + i)) begin
        bad++; $display("FAIL rearm_mem%0d: got %0h exp %0h", i, mem[i], 8'h60 + i);
      end
    end
    total++;
    if (wr_total != N || order_bad || cmp_cnt != 1 || num_at_comp !== AW'(N) || o_num_cnt !== AW'(N)) begin
      bad++; $display("FAIL rearm_sum: n=%0d order_bad=%b pulses=%0d num=%0d exp 12 0 1 12",
        wr_total, order_bad, cmp_cnt, o_num_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gappy();
    test_framing_err();
    test_hold_release();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
